// File: rtl/cpu_ctrl.sv
// Instruction-fetch and register-move controller: fetches a byte into IR, then
// executes MOVE (reg -> reg) or MOVI (imm -> reg) against an external register file.
module cpu_ctrl #(
    parameter int unsigned DW  = 8,
    parameter int unsigned TMO = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch,
    input  logic          start_move,
    input  logic          start_movi,
    input  logic [7:0]    mem_data,
    input  logic          mem_ready,
    output logic          mem_rd,
    output logic          pc_inc,
    output logic [7:0]    ir,
    output logic [1:0]    rf_raddr,
    output logic [1:0]    rf_waddr,
    output logic          rf_we,
    output logic          bus_sel,
    output logic [DW-1:0] imm_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StMemWait,
        StMoveRd,
        StMoveWr,
        StMoviWr,
        StDone
    } state_e;

    // Last MEM_WAIT cycle that may still see mem_ready before timing out.
    localparam logic [7:0] TmoLast = 8'(TMO - 1);

    state_e     state_q, state_d;
    logic       fetch_pend_q, fetch_pend_d;
    logic       move_pend_q, move_pend_d;
    logic       movi_pend_q, movi_pend_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] ir_q, ir_d;
    logic       err_q, err_d;
    logic       pc_inc_q, pc_inc_d;

    logic fetch_eff, move_eff, movi_eff;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            fetch_pend_q <= 1'b0;
            move_pend_q  <= 1'b0;
            movi_pend_q  <= 1'b0;
            wait_cnt_q   <= 8'd0;
            ir_q         <= 8'd0;
            err_q        <= 1'b0;
            pc_inc_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pend_q <= fetch_pend_d;
            move_pend_q  <= move_pend_d;
            movi_pend_q  <= movi_pend_d;
            wait_cnt_q   <= wait_cnt_d;
            ir_q         <= ir_d;
            err_q        <= err_d;
            pc_inc_q     <= pc_inc_d;
        end
    end

    // A request seen in IDLE is treated as if its pending flag were already set.
    assign fetch_eff = fetch_pend_q | fetch;
    assign move_eff  = move_pend_q | start_move;
    assign movi_eff  = movi_pend_q | start_movi;

    always_comb begin
        state_d      = state_q;
        fetch_pend_d = fetch_eff;
        move_pend_d  = move_eff;
        movi_pend_d  = movi_eff;
        wait_cnt_d   = wait_cnt_q;
        ir_d         = ir_q;
        err_d        = err_q;
        pc_inc_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fetch_eff) begin
                    state_d      = StFetch;
                    fetch_pend_d = 1'b0;
                end else if (move_eff) begin
                    state_d     = StMoveRd;
                    move_pend_d = 1'b0;
                end else if (movi_eff) begin
                    state_d     = StMoviWr;
                    movi_pend_d = 1'b0;
                end
            end
            StFetch: begin
                state_d    = StMemWait;
                wait_cnt_d = 8'd0;
            end
            StMemWait: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (mem_ready) begin
                    ir_d     = mem_data;
                    pc_inc_d = 1'b1;
                    state_d  = StDone;
                end else if (wait_cnt_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StMoveRd: state_d = StMoveWr;
            StMoveWr: state_d = StDone;
            StMoviWr: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only; no input reaches an output combinationally.
    always_comb begin
        mem_rd   = (state_q == StFetch) || (state_q == StMemWait);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        rf_we    = (state_q == StMoveWr) || (state_q == StMoviWr);
        bus_sel  = (state_q == StMoviWr);
        rf_raddr = 2'd0;
        rf_waddr = 2'd0;
        if ((state_q == StMoveRd) || (state_q == StMoveWr)) begin
            rf_raddr = ir_q[5:4];
        end
        if (rf_we) begin
            rf_waddr = ir_q[7:6];
        end
    end

    assign imm_out = DW'(ir_q[3:0]);
    assign ir      = ir_q;
    assign err     = err_q;
    assign pc_inc  = pc_inc_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: fetch, MOVE, MOVI, queued requests, timeout and reset abort.
module tb_cpu_ctrl;

    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch;
    logic          start_move;
    logic          start_movi;
    logic [7:0]    mem_data;
    logic          mem_ready;
    logic          mem_rd;
    logic          pc_inc;
    logic [7:0]    ir;
    logic [1:0]    rf_raddr;
    logic [1:0]    rf_waddr;
    logic          rf_we;
    logic          bus_sel;
    logic [DW-1:0] imm_out;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_ctrl #(
        .DW (DW),
        .TMO(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch     (fetch),
        .start_move(start_move),
        .start_movi(start_movi),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .pc_inc    (pc_inc),
        .ir        (ir),
        .rf_raddr  (rf_raddr),
        .rf_waddr  (rf_waddr),
        .rf_we     (rf_we),
        .bus_sel   (bus_sel),
        .imm_out   (imm_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_rd, pc_inc, rf_we, bus_sel, busy, done, err} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0000000",
                     {mem_rd, pc_inc, rf_we, bus_sel, busy, done, err});
        else n_pass++;
        n_checks++;
        if ({rf_raddr, rf_waddr} !== 4'b0)
            $display("FAIL reset_addr: got %b want 0000", {rf_raddr, rf_waddr});
        else n_pass++;
        n_checks++;
        if (imm_out !== 8'h00) $display("FAIL reset_imm: got %h want 00", imm_out);
        else n_pass++;
        n_checks++;
        if (ir !== 8'h00) $display("FAIL reset_ir: got %h want 00", ir);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Ready arrives in the 2nd MEM_WAIT cycle (cycle 3 after the request edge).
    task automatic test_fetch();
        int done_cnt = 0, done_cyc = 0, pc_cnt = 0, pc_cyc = 0, rd_cnt = 0, busy_cnt = 0;
        fetch = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) fetch = 1'b0;
            if (done) begin done_cnt++; done_cyc = c; end
            if (pc_inc) begin pc_cnt++; pc_cyc = c; end
            if (mem_rd) rd_cnt++;
            if (busy) busy_cnt++;
            mem_ready = (c == 3);
            mem_data  = (c == 3) ? 8'h6A : 8'h00;
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 4)
            $display("FAIL fetch_done: got cnt=%0d cyc=%0d want cnt=1 cyc=4", done_cnt, done_cyc);
        else n_pass++;
        n_checks++;
        if (pc_cnt !== 1 || pc_cyc !== 4)
            $display("FAIL fetch_pc_inc: got cnt=%0d cyc=%0d want cnt=1 cyc=4", pc_cnt, pc_cyc);
        else n_pass++;
        n_checks++;
        if (rd_cnt !== 3) $display("FAIL fetch_mem_rd: got %0d cycles want 3", rd_cnt);
        else n_pass++;
        n_checks++;
        if (busy_cnt !== 4) $display("FAIL fetch_busy: got %0d cycles want 4", busy_cnt);
        else n_pass++;
        n_checks++;
        if (ir !== 8'h6A || err !== 1'b0)
            $display("FAIL fetch_ir: got ir=%h err=%b want ir=6a err=0", ir, err);
        else n_pass++;
    endtask

    // ir = 6A: dst = 1, src = 2.
    task automatic test_move();
        int we_cnt = 0, we_cyc = 0, done_cyc = 0;
        logic [1:0] raddr_c1 = 2'd0, raddr_w = 2'd0, waddr_w = 2'd0;
        logic bsel_w = 1'b1;
        start_move = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin start_move = 1'b0; raddr_c1 = rf_raddr; end
            if (rf_we) begin
                we_cnt++; we_cyc = c; raddr_w = rf_raddr; waddr_w = rf_waddr; bsel_w = bus_sel;
            end
            if (done) done_cyc = c;
        end
        n_checks++;
        if (raddr_c1 !== 2'd2) $display("FAIL move_rd_raddr: got %0d want 2", raddr_c1);
        else n_pass++;
        n_checks++;
        if (we_cnt !== 1 || we_cyc !== 2)
            $display("FAIL move_we: got cnt=%0d cyc=%0d want cnt=1 cyc=2", we_cnt, we_cyc);
        else n_pass++;
        n_checks++;
        if (raddr_w !== 2'd2 || waddr_w !== 2'd1 || bsel_w !== 1'b0)
            $display("FAIL move_wr_addr: got r=%0d w=%0d sel=%b want r=2 w=1 sel=0",
                     raddr_w, waddr_w, bsel_w);
        else n_pass++;
        n_checks++;
        if (done_cyc !== 3) $display("FAIL move_done: got cyc=%0d want 3", done_cyc);
        else n_pass++;
    endtask

    task automatic test_movi();
        int done_cyc = 0, we_cnt = 0, we_cyc = 0;
        logic [1:0] waddr_w = 2'd0;
        logic [7:0] imm_w = 8'h00;
        logic bsel_w = 1'b0;
        // Load ir = C5 with ready already high: no wait cycles.
        fetch = 1'b1;
        mem_ready = 1'b1;
        mem_data = 8'hC5;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) fetch = 1'b0;
            if (done) done_cyc = c;
        end
        mem_ready = 1'b0;
        n_checks++;
        if (done_cyc !== 3 || ir !== 8'hC5)
            $display("FAIL fetch_nowait: got cyc=%0d ir=%h want cyc=3 ir=c5", done_cyc, ir);
        else n_pass++;
        done_cyc = 0;
        start_movi = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start_movi = 1'b0;
            if (rf_we) begin
                we_cnt++; we_cyc = c; waddr_w = rf_waddr; imm_w = imm_out; bsel_w = bus_sel;
            end
            if (done) done_cyc = c;
        end
        n_checks++;
        if (we_cnt !== 1 || we_cyc !== 1)
            $display("FAIL movi_we: got cnt=%0d cyc=%0d want cnt=1 cyc=1", we_cnt, we_cyc);
        else n_pass++;
        n_checks++;
        if (waddr_w !== 2'd3 || imm_w !== 8'h05 || bsel_w !== 1'b1)
            $display("FAIL movi_data: got w=%0d imm=%h sel=%b want w=3 imm=05 sel=1",
                     waddr_w, imm_w, bsel_w);
        else n_pass++;
        n_checks++;
        if (done_cyc !== 2) $display("FAIL movi_done: got cyc=%0d want 2", done_cyc);
        else n_pass++;
    endtask

    // All three requests in one IDLE cycle; start_move held a second cycle must be absorbed.
    task automatic test_back_to_back();
        int d[3];
        int w[2];
        int dcnt = 0, wcnt = 0, pc_cnt = 0;
        logic [1:0] waddr_w[2];
        logic [1:0] raddr_w0 = 2'd0;
        logic bsel_w[2];
        logic [7:0] imm_w1 = 8'h00;
        fetch = 1'b1;
        start_move = 1'b1;
        start_movi = 1'b1;
        mem_ready = 1'b1;
        mem_data = 8'h9B;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin fetch = 1'b0; start_movi = 1'b0; end
            if (c == 2) start_move = 1'b0;
            if (done) begin
                if (dcnt < 3) d[dcnt] = c;
                dcnt++;
            end
            if (rf_we) begin
                if (wcnt < 2) begin
                    w[wcnt] = c; waddr_w[wcnt] = rf_waddr; bsel_w[wcnt] = bus_sel;
                end
                if (wcnt == 0) raddr_w0 = rf_raddr;
                if (wcnt == 1) imm_w1 = imm_out;
                wcnt++;
            end
            if (pc_inc) pc_cnt++;
        end
        mem_ready = 1'b0;
        n_checks++;
        if (dcnt !== 3 || d[0] !== 3 || d[1] !== 7 || d[2] !== 10)
            $display("FAIL b2b_done: got cnt=%0d cyc=%0d,%0d,%0d want cnt=3 cyc=3,7,10",
                     dcnt, d[0], d[1], d[2]);
        else n_pass++;
        n_checks++;
        if (wcnt !== 2 || w[0] !== 6 || w[1] !== 9)
            $display("FAIL b2b_we: got cnt=%0d cyc=%0d,%0d want cnt=2 cyc=6,9", wcnt, w[0], w[1]);
        else n_pass++;
        n_checks++;
        if (waddr_w[0] !== 2'd2 || raddr_w0 !== 2'd1 || bsel_w[0] !== 1'b0)
            $display("FAIL b2b_move: got w=%0d r=%0d sel=%b want w=2 r=1 sel=0",
                     waddr_w[0], raddr_w0, bsel_w[0]);
        else n_pass++;
        n_checks++;
        if (waddr_w[1] !== 2'd2 || imm_w1 !== 8'h0B || bsel_w[1] !== 1'b1)
            $display("FAIL b2b_movi: got w=%0d imm=%h sel=%b want w=2 imm=0b sel=1",
                     waddr_w[1], imm_w1, bsel_w[1]);
        else n_pass++;
        n_checks++;
        if (pc_cnt !== 1 || ir !== 8'h9B)
            $display("FAIL b2b_fetch: got pc=%0d ir=%h want pc=1 ir=9b", pc_cnt, ir);
        else n_pass++;
    endtask

    // TMO = 6: MEM_WAIT occupies cycles 2..7, DONE with err in cycle 8.
    task automatic test_timeout();
        int done_cyc = 0, pc_cnt = 0;
        logic err7 = 1'b1, err8 = 1'b0;
        fetch = 1'b1;
        mem_ready = 1'b0;
        mem_data = 8'hFF;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) fetch = 1'b0;
            if (done) done_cyc = c;
            if (pc_inc) pc_cnt++;
            if (c == 7) err7 = err;
            if (c == 8) err8 = err;
        end
        n_checks++;
        if (done_cyc !== 8) $display("FAIL tmo_done: got cyc=%0d want 8", done_cyc);
        else n_pass++;
        n_checks++;
        if (err7 !== 1'b0 || err8 !== 1'b1)
            $display("FAIL tmo_err: got c7=%b c8=%b want c7=0 c8=1", err7, err8);
        else n_pass++;
        n_checks++;
        if (pc_cnt !== 0 || ir !== 8'h9B)
            $display("FAIL tmo_ir: got pc=%0d ir=%h want pc=0 ir=9b", pc_cnt, ir);
        else n_pass++;
        done_cyc = 0;
        start_movi = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start_movi = 1'b0;
            if (done) done_cyc = c;
        end
        n_checks++;
        if (err !== 1'b1 || done_cyc !== 2)
            $display("FAIL tmo_sticky: got err=%b cyc=%0d want err=1 cyc=2", err, done_cyc);
        else n_pass++;
    endtask

    // Reset sampled at the end of MOVE_RD, with a MOVI request arriving the same edge.
    task automatic test_reset_mid();
        int we_cnt = 0, pc_cnt = 0, busy_after = 0;
        logic busy_c1 = 1'b0;
        logic [1:0] raddr_c1 = 2'd0;
        logic [6:0] flags_c2 = 7'h7F;
        logic [15:0] data_c2 = 16'hFFFF;
        logic [3:0] addr_c2 = 4'hF;
        start_move = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (rf_we) we_cnt++;
            if (pc_inc) pc_cnt++;
            if (c == 1) begin
                busy_c1 = busy; raddr_c1 = rf_raddr;
                start_move = 1'b0; start_movi = 1'b1; reset = 1'b0;
            end
            if (c == 2) begin
                flags_c2 = {mem_rd, pc_inc, rf_we, bus_sel, busy, done, err};
                data_c2 = {ir, imm_out};
                addr_c2 = {rf_raddr, rf_waddr};
                start_movi = 1'b0;
            end
            if (c == 3) reset = 1'b1;
            if (c >= 4 && busy) busy_after++;
        end
        n_checks++;
        if (busy_c1 !== 1'b1 || raddr_c1 !== 2'd1)
            $display("FAIL rst_mid_state: got busy=%b r=%0d want busy=1 r=1", busy_c1, raddr_c1);
        else n_pass++;
        n_checks++;
        if (flags_c2 !== 7'b0 || addr_c2 !== 4'b0 || data_c2 !== 16'h0)
            $display("FAIL rst_mid_outputs: got flags=%b addr=%b data=%h want all 0",
                     flags_c2, addr_c2, data_c2);
        else n_pass++;
        n_checks++;
        if (we_cnt !== 0 || pc_cnt !== 0)
            $display("FAIL rst_mid_abort: got we=%0d pc=%0d want 0 0", we_cnt, pc_cnt);
        else n_pass++;
        n_checks++;
        if (busy_after !== 0)
            $display("FAIL rst_mid_pending: got %0d busy cycles want 0", busy_after);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        fetch = 1'b0;
        start_move = 1'b0;
        start_movi = 1'b0;
        mem_data = 8'h00;
        mem_ready = 1'b0;
        test_reset();
        test_fetch();
        test_move();
        test_movi();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the register-file data width in bits (DW >= 4).
REQ-002 The block SHALL have parameter TMO, default 15, meaning the maximum number of cycles to wait for mem_ready (1..255).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 Port fetch, input, 1 bit: request to fetch one instruction byte into IR.
REQ-006 Port start_move, input, 1 bit: request to execute MOVE, dst <- src register.
REQ-007 Port start_movi, input, 1 bit: request to execute MOVI, dst <- zero-extended immediate.
REQ-008 Port mem_data, input, 8 bits: instruction byte from memory.
REQ-009 Port mem_ready, input, 1 bit: mem_data is valid this cycle.
REQ-010 Port mem_rd, output, 1 bit: memory read strobe.
REQ-011 Port pc_inc, output, 1 bit: one-cycle program-counter increment.
REQ-012 Port ir, output, 8 bits: instruction register; ir[7:6] = dst, ir[5:4] = src, ir[3:0] = imm.
REQ-013 Port rf_raddr and rf_waddr, output, 2 bits each: register-file read and write addresses.
REQ-014 Port rf_we, output, 1 bit: register-file write enable.
REQ-015 Port bus_sel, output, 1 bit: 0 = register read data drives the bus, 1 = imm_out drives it.
REQ-016 Port imm_out, output, DW bits: {(DW-4) zeros, ir[3:0]}.
REQ-017 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-018 Port done, output, 1 bit: one-cycle completion pulse.
REQ-019 Port err, output, 1 bit: sticky memory-timeout flag.

Function
REQ-020 The FSM SHALL have these states: IDLE, FETCH, MEM_WAIT, MOVE_RD, MOVE_WR, MOVI_WR, DONE.
REQ-021 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.
REQ-022 Requests SHALL be sampled at each rising edge; the block captures no sub-cycle pulses.
REQ-023 Each request type SHALL have a pending flag, set when its request is sampled high in any state.
REQ-024 Re-assertion of a request whose pending flag is already set SHALL be absorbed (no count).
REQ-025 In IDLE, service order SHALL be fetch > move > movi; the winner's pending flag clears on the transition.
REQ-026 A request sampled in IDLE SHALL be serviced directly from IDLE, equivalent to a pending flag set that cycle.
REQ-027 FETCH SHALL last 1 cycle with mem_rd = 1, then go to MEM_WAIT.
REQ-028 In MEM_WAIT, mem_rd SHALL stay 1 and a wait counter SHALL increment each cycle.
REQ-029 In MEM_WAIT, mem_ready = 1 SHALL load ir <= mem_data, pulse pc_inc for 1 cycle, and go to DONE.
REQ-030 In MEM_WAIT, if the counter reaches TMO with mem_ready still 0, the FSM SHALL set err, leave ir and pc unchanged, and go to DONE.
REQ-031 MOVE_RD SHALL last 1 cycle with rf_raddr = ir[5:4] and bus_sel = 0, then go to MOVE_WR.
REQ-032 MOVE_WR SHALL assert rf_we = 1, rf_waddr = ir[7:6], rf_raddr = ir[5:4], bus_sel = 0, then go to DONE.
REQ-033 MOVI_WR SHALL assert rf_we = 1, rf_waddr = ir[7:6], bus_sel = 1, then go to DONE.
REQ-034 DONE SHALL assert done for 1 cycle and return to IDLE.
REQ-035 Latency from the sampled request edge to the done pulse SHALL be: MOVE 3 cycles, MOVI 2 cycles, fetch 3 + wait cycles.
REQ-036 rf_we SHALL be asserted only in MOVE_WR and MOVI_WR; src == dst SHALL still perform the write.
REQ-037 err SHALL clear only on reset.

Reset
REQ-038 With reset = 0 at a rising edge, the state SHALL become IDLE, all pending flags 0, the wait counter 0, ir = 0, err = 0.
REQ-039 During reset, all outputs SHALL be 0: mem_rd, pc_inc, rf_we, bus_sel, rf_raddr, rf_waddr, imm_out, busy, done.
REQ-040 Reset asserted mid-operation SHALL abort with no rf_we and no pc_inc, and discard pending requests.

Verification
REQ-041 Fetch with mem_ready at the 2nd MEM_WAIT cycle and mem_data = 8'h6A -> ir = 8'h6A, one pc_inc, done 4 cycles after the request edge.
REQ-042 With ir = 8'h6A, pulse start_move -> MOVE_WR shows rf_raddr = 2, rf_waddr = 1, rf_we = 1 for exactly 1 cycle, done 3 cycles after the request edge.
REQ-043 With ir = 8'hC5, pulse start_movi -> rf_waddr = 3, imm_out = 8'h05, bus_sel = 1, rf_we = 1 for 1 cycle, done 2 cycles after the request edge.
REQ-044 Fetch, start_move and start_movi all high in one IDLE cycle -> executed in order fetch, MOVE, MOVI, each done separately, no request lost.
REQ-045 Fetch with mem_ready held 0 -> err = 1 after TMO wait cycles, ir unchanged, no pc_inc, done pulses, err persists until reset.
REQ-046 reset = 0 during MOVE_RD -> next cycle IDLE, rf_we never asserted, all outputs 0.
